// File: rtl/branch_predict_unit_pkg.sv
// rtl/branch_predict_unit_pkg.sv - shared constants and 2-bit counter helpers for the branch predictor
package branch_predict_unit_pkg;

    localparam logic [31:0] BPU_RESET_PC = 32'h1c00_0000;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } ctr_e;

    // Saturating step towards the observed direction; the ends never wrap.
    function automatic ctr_e ctr_train(input ctr_e c, input logic taken);
        ctr_e n;
        unique case (c)
            CTR_SNT: n = taken ? CTR_WNT : CTR_SNT;
            CTR_WNT: n = taken ? CTR_WT  : CTR_SNT;
            CTR_WT:  n = taken ? CTR_ST  : CTR_WNT;
            default: n = taken ? CTR_ST  : CTR_WT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// rtl/branch_predict_unit_if.sv - fetch, redirect and training signals between predictor and pipeline
interface branch_predict_unit_if;
    logic        fetch_ready;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [31:0] pred_pc;
    logic        br_taken_cancel;
    logic [31:0] redirect_pc;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;

    modport master (
        output fetch_valid, fetch_pc, pred_pc,
        input  fetch_ready, br_taken_cancel, redirect_pc,
        input  upd_valid, upd_pc, upd_taken, upd_target
    );

    modport slave (
        input  fetch_valid, fetch_pc, pred_pc,
        output fetch_ready, br_taken_cancel, redirect_pc,
        output upd_valid, upd_pc, upd_taken, upd_target
    );
endinterface

// File: rtl/branch_predict_unit_btb.sv
// rtl/branch_predict_unit_btb.sv - direct-mapped BTB: combinational lookup, synchronous training write
module branch_predict_unit_btb
    import branch_predict_unit_pkg::*;
#(
    parameter int BTB_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:2] rd_pc,
    output logic        rd_taken,
    output logic [31:0] rd_target,
    input  logic        wr_en,
    input  logic [31:2] wr_pc,
    input  logic        wr_taken,
    input  logic [31:0] wr_target
);
    localparam int IDX_W = $clog2(BTB_ENTRIES);
    localparam int TAG_W = 30 - IDX_W;

    logic [BTB_ENTRIES-1:0] valid;
    logic [TAG_W-1:0]       tag_mem    [BTB_ENTRIES];
    logic [31:0]            target_mem [BTB_ENTRIES];
    ctr_e                   ctr_mem    [BTB_ENTRIES];

    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic [TAG_W-1:0] rd_tag, wr_tag;
    logic             rd_hit, wr_hit;

    assign rd_idx    = rd_pc[IDX_W+1:2];
    assign rd_tag    = rd_pc[31:IDX_W+2];
    assign rd_hit    = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
    assign rd_taken  = rd_hit && ctr_mem[rd_idx][1];
    assign rd_target = target_mem[rd_idx];

    assign wr_idx = wr_pc[IDX_W+1:2];
    assign wr_tag = wr_pc[31:IDX_W+2];
    assign wr_hit = valid[wr_idx] && (tag_mem[wr_idx] == wr_tag);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid <= '0;
        end else if (wr_en && !wr_hit && wr_taken) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    // Payload is not reset: an entry is meaningless until its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (wr_hit) begin
                ctr_mem[wr_idx] <= ctr_train(ctr_mem[wr_idx], wr_taken);
                if (wr_taken) begin
                    target_mem[wr_idx] <= wr_target;
                end
            end else if (wr_taken) begin
                tag_mem[wr_idx]    <= wr_tag;
                target_mem[wr_idx] <= wr_target;
                ctr_mem[wr_idx]    <= CTR_WT;
            end
        end
    end

endmodule

// File: rtl/branch_predict_unit.sv
// rtl/branch_predict_unit.sv - fetch PC register and BTB next-PC prediction; BP_PERF_CNT_EN adds perf counters
module branch_predict_unit
    import branch_predict_unit_pkg::*;
#(
    parameter int          BTB_ENTRIES = 16,
    parameter logic [31:0] RESET_PC    = BPU_RESET_PC
) (
    input  logic                  clk,
    input  logic                  resetn,
    branch_predict_unit_if.master bpu
`ifdef BP_PERF_CNT_EN
    ,
    output logic [31:0]           perf_br_cnt,
    output logic [31:0]           perf_mispred_cnt
`endif
);
    logic [31:0] pc_q;
    logic        valid_q;
    logic        btb_taken;
    logic [31:0] btb_target;
    logic [1:0]  unused_upd_lsb;

    assign unused_upd_lsb = bpu.upd_pc[1:0];

    branch_predict_unit_btb #(
        .BTB_ENTRIES(BTB_ENTRIES)
    ) u_btb (
        .clk       (clk),
        .resetn    (resetn),
        .rd_pc     (pc_q[31:2]),
        .rd_taken  (btb_taken),
        .rd_target (btb_target),
        .wr_en     (bpu.upd_valid),
        .wr_pc     (bpu.upd_pc[31:2]),
        .wr_taken  (bpu.upd_taken),
        .wr_target (bpu.upd_target)
    );

    // The instruction fetched during a redirect cycle is wrong-path, so it is never offered.
    assign bpu.fetch_pc    = pc_q;
    assign bpu.fetch_valid = valid_q && !bpu.br_taken_cancel;
    assign bpu.pred_pc     = btb_taken ? btb_target : pc_q + 32'd4;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            pc_q    <= RESET_PC;
            valid_q <= 1'b0;
        end else begin
            valid_q <= 1'b1;
            if (bpu.br_taken_cancel) begin
                pc_q <= bpu.redirect_pc;
            end else if (bpu.fetch_valid && bpu.fetch_ready) begin
                pc_q <= bpu.pred_pc;
            end
        end
    end

`ifdef BP_PERF_CNT_EN
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (bpu.upd_valid) begin
                perf_br_cnt <= perf_br_cnt + 32'd1;
            end
            if (bpu.br_taken_cancel) begin
                perf_mispred_cnt <= perf_mispred_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_predict_unit.sv
// tb/tb_branch_predict_unit.sv - directed and random checks of branch_predict_unit against a table model
module tb_branch_predict_unit;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    branch_predict_unit_if bif();

`ifdef BP_PERF_CNT_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    branch_predict_unit #(
        .BTB_ENTRIES (16),
        .RESET_PC    (32'h1c00_0000)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bpu    (bif)
`ifdef BP_PERF_CNT_EN
        ,
        .perf_br_cnt      (perf_br_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        bit        v;
        bit [25:0] tag;
        bit [31:0] tgt;
        int        ctr;
    } ent_t;

    ent_t      m_btb [16];
    bit [31:0] m_pc;
    bit        m_vq;
    bit [31:0] m_br;
    bit [31:0] m_mis;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_pc  = 32'h1c00_0000;
        m_vq  = 1'b0;
        m_br  = '0;
        m_mis = '0;
        for (int i = 0; i < 16; i++) m_btb[i].v = 1'b0;
    endfunction

    function automatic bit [31:0] m_pred(input bit [31:0] pc);
        bit [3:0] i;
        bit       hit;
        i   = pc[5:2];
        hit = m_btb[i].v && (m_btb[i].tag == pc[31:6]);
        return (hit && m_btb[i].ctr >= 2) ? m_btb[i].tgt : pc + 32'd4;
    endfunction

    function automatic bit [31:0] rnd_pc();
        bit [5:0] w;
        w = 6'($urandom_range(0, 63));
        return {26'h070_0000, w, 2'b00};
    endfunction

    task automatic step(input bit rn, input bit rdy, input bit cnl, input bit [31:0] rpc,
                        input bit uv, input bit [31:0] upc, input bit ut, input bit [31:0] utg);
        bit [31:0] pred;
        bit        ev;
        bit [3:0]  ui;
        bit        uhit;
        resetn              = rn;
        bif.fetch_ready     = rdy;
        bif.br_taken_cancel = cnl;
        bif.redirect_pc     = rpc;
        bif.upd_valid       = uv;
        bif.upd_pc          = upc;
        bif.upd_taken       = ut;
        bif.upd_target      = utg;
        if (!rn) m_reset();
        @(negedge clk);
        pred = m_pred(m_pc);
        ev   = m_vq && !cnl;
        chk("fetch_valid", 32'(bif.fetch_valid), 32'(ev));
        chk("fetch_pc", bif.fetch_pc, m_pc);
        chk("pred_pc", bif.pred_pc, pred);
`ifdef BP_PERF_CNT_EN
        chk("perf_br_cnt", perf_br_cnt, m_br);
        chk("perf_mispred_cnt", perf_mispred_cnt, m_mis);
`endif
        @(posedge clk);
        if (rn) begin
            m_vq = 1'b1;
            if (cnl) m_pc = rpc;
            else if (ev && rdy) m_pc = pred;
            if (uv) begin
                ui   = upc[5:2];
                uhit = m_btb[ui].v && (m_btb[ui].tag == upc[31:6]);
                if (uhit) begin
                    if (ut) begin
                        m_btb[ui].ctr = (m_btb[ui].ctr == 3) ? 3 : m_btb[ui].ctr + 1;
                        m_btb[ui].tgt = utg;
                    end else begin
                        m_btb[ui].ctr = (m_btb[ui].ctr == 0) ? 0 : m_btb[ui].ctr - 1;
                    end
                end else if (ut) begin
                    m_btb[ui] = '{1'b1, upc[31:6], utg, 2};
                end
                m_br = m_br + 32'd1;
            end
            if (cnl) m_mis = m_mis + 32'd1;
        end
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(1'b1, rdy, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic train(input bit [31:0] pc, input bit taken, input bit [31:0] tgt);
        step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1, pc, taken, tgt);
    endtask

    task automatic redirect(input bit [31:0] pc);
        step(1'b1, 1'b0, 1'b1, pc, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        m_reset();
        step(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("rst_pc", bif.fetch_pc, 32'h1c00_0000);
        chk("rst_valid", 32'(bif.fetch_valid), 32'h0);

        idle(1'b1);
        chk("first_pc", bif.fetch_pc, 32'h1c00_0000);
        chk("first_valid", 32'(bif.fetch_valid), 32'h1);
        idle(1'b1);
        chk("seq_pc1", bif.fetch_pc, 32'h1c00_0004);
        idle(1'b1);
        chk("seq_pc2", bif.fetch_pc, 32'h1c00_0008);
        chk("seq_pred2", bif.pred_pc, 32'h1c00_000c);

        for (int i = 0; i < 3; i++) idle(1'b0);
        chk("hold_pc", bif.fetch_pc, 32'h1c00_0008);

        train(32'h1c00_0010, 1'b1, 32'h1c00_0100);
        redirect(32'h1c00_0010);
        chk("alloc_pc", bif.fetch_pc, 32'h1c00_0010);
        chk("alloc_pred", bif.pred_pc, 32'h1c00_0100);
        train(32'h1c00_0010, 1'b0, 32'h0);
        train(32'h1c00_0010, 1'b0, 32'h0);
        chk("dec_pred", bif.pred_pc, 32'h1c00_0014);
        train(32'h1c00_0010, 1'b0, 32'h0);
        chk("sat_low_pred", bif.pred_pc, 32'h1c00_0014);
        train(32'h1c00_0010, 1'b1, 32'h1c00_0100);
        chk("wnt_pred", bif.pred_pc, 32'h1c00_0014);
        train(32'h1c00_0010, 1'b1, 32'h1c00_0100);
        chk("wt_pred", bif.pred_pc, 32'h1c00_0100);

        redirect(32'h1c00_0200);
        idle(1'b0);
        chk("redir_pc", bif.fetch_pc, 32'h1c00_0200);
        chk("redir_valid", 32'(bif.fetch_valid), 32'h1);

        redirect(32'h1c00_0050);
        chk("alias_pred", bif.pred_pc, 32'h1c00_0054);
        step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1, 32'h1c00_0050, 1'b1, 32'h1c00_0500);
        chk("same_idx_pc", bif.fetch_pc, 32'h1c00_0054);

        redirect(32'hffff_fffc);
        chk("wrap_pred", bif.pred_pc, 32'h0000_0000);
        idle(1'b1);
        chk("wrap_pc", bif.fetch_pc, 32'h0000_0000);

        step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        chk("midrst_pc", bif.fetch_pc, 32'h1c00_0000);
        train(32'h1c00_0010, 1'b0, 32'h0);
        train(32'h1c00_0020, 1'b1, 32'h1c00_0300);
        redirect(32'h1c00_0010);
        chk("lost_pred", bif.pred_pc, 32'h1c00_0014);
`ifdef BP_PERF_CNT_EN
        chk("perf_br_2", perf_br_cnt, 32'd2);
        chk("perf_mis_1", perf_mispred_cnt, 32'd1);
`endif

        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 99) != 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 7) == 0, rnd_pc(),
                 $urandom_range(0, 1) == 1, rnd_pc(),
                 $urandom_range(0, 2) != 0, rnd_pc());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
